multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I datapath.
- Sequences fetch, decode, execute, memory and writeback over one shared ALU and one shared memory port.
- Drives the 3-bit immediate-format select (imm_src) consumed by the sign-extender, plus all datapath mux, write-enable and ALU-op controls.
- Owns the memory request handshake, including a bounded wait timeout.

Parameters:
- MAX_WAIT, 255: cycles with mem_req high and mem_ready low before timeout. Range 1..255; wait counter is 8 bits.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0], from IR
- funct3  in  3  instr[14:12], from IR
- zero  in  1  ALU result == 0
- lt  in  1  signed rs1 < rs2
- ltu  in  1  unsigned rs1 < rs2
- mem_ready  in  1  memory completes the current request
- mem_req  out  1  memory request
- mem_we  out  1  write qualifier for mem_req
- adr_src  out  1  address select: 0 = PC, 1 = alu_out register
- ir_write  out  1  IR and old_pc load enable
- pc_write  out  1  PC load enable
- reg_write  out  1  register file write enable
- result_src  out  2  result select: 00 = alu_out register, 01 = mem data, 10 = ALU result direct
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = old_pc, 10 = rs1, 11 = zero
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4
- alu_op  out  2  00 = add, 01 = compare/sub, 10 = funct-decoded
- imm_src  out  3  immediate format select
- instr_retired  out  1  one-cycle pulse per completed instruction
- bus_err  out  1  sticky memory-timeout flag
- illegal_instr  out  1  sticky illegal-instruction flag

Behaviour:
- Clock and reset:
  - One clock domain; rst_n asynchronous, active low.
  - Reset forces state RST and clears wait_cnt, bus_err and illegal_instr.
  - In RST all outputs are 0. First clock edge after rst_n rises enters FETCH.
- Outputs are combinational from state and inputs. Any output not listed for a state is 0.
- imm_src depends on opcode only, in every state except RST/HALT/TRAP (000 there):
  - 0000011, 0010011, 1100111 → 000
  - 0100011 → 001
  - 1100011 → 010
  - 1101111 → 011
  - 0110111, 0010111 → 100
  - 1110011 → 101
  - all other opcodes → 000
- State FETCH: adr_src=0, mem_req=1, a=00, b=10, alu_op=00, result_src=10. On mem_ready: ir_write=1, pc_write=1, next DECODE. Otherwise hold.
- State DECODE: a=01, b=01, alu_op=00 (alu_out ← old_pc+imm). Next state by opcode:
  - load/store → MEMADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - branch → BRANCH
  - JAL → JAL
  - JALR → JALR
  - LUI → LUI
  - AUIPC → ALU_WB
  - other → FETCH, no retire pulse
- State MEMADR: a=10, b=01, alu_op=00. Load → MEMRD; store → MEMWR.
- State MEMRD: adr_src=1, mem_req=1. On mem_ready → MEMWB.
- State MEMWB: result_src=01, reg_write=1, instr_retired=1 → FETCH.
- State MEMWR: adr_src=1, mem_req=1, mem_we=1. On mem_ready: instr_retired=1 → FETCH.
- State EXEC_R: a=10, b=00, alu_op=10 → ALU_WB.
- State EXEC_I: a=10, b=01, alu_op=10 → ALU_WB.
- State ALU_WB: result_src=00, reg_write=1, instr_retired=1 → FETCH.
- State BRANCH: a=10, b=00, alu_op=01, result_src=00, instr_retired=1 → FETCH.
  - pc_write=taken, where taken by funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
  - funct3 010/011: taken=0.
- State JAL: result_src=00, pc_write=1, a=01, b=10, alu_op=00 → ALU_WB.
- State JALR: a=10, b=01, alu_op=00, result_src=10, pc_write=1 → JALR_LINK. Datapath clears bit 0 of the target.
- State JALR_LINK: a=01, b=10, alu_op=00 → ALU_WB.
- State LUI: a=11, b=01, alu_op=00 → ALU_WB.
- Memory handshake and timeout:
  - mem_req stays high until mem_ready. Completion takes effect in the same cycle mem_ready is sampled high.
  - wait_cnt increments each cycle mem_req && !mem_ready, and clears on mem_ready or on leaving the state.
  - When wait_cnt == MAX_WAIT-1 and mem_ready is low: next HALT, bus_err ← 1.
  - mem_ready in the final timeout cycle completes normally.
- State HALT: all controls 0, bus_err held. Exit only via rst_n.
- Reset mid-instruction: immediate return to RST with outputs 0. No partial write is signalled after rst_n falls.

Optional Feature:
- Macro ILLEGAL_INSTR_TRAP_EN.
- Defined:
  - DECODE with an unknown opcode, or BRANCH with funct3 010/011, goes to TRAP.
  - For the bad branch, pc_write=0 and instr_retired=0.
  - TRAP: illegal_instr=1 sticky, all other controls 0. Exit only via rst_n.
- Undefined:
  - Unknown opcode → FETCH as a NOP.
  - Bad branch funct3 is not taken and retires.
  - illegal_instr tied 0.

Test Plan:
- Reset held, then released; mem_ready=1 always → RST outputs all 0. FETCH mem_req=1 one cycle after release. ir_write=pc_write=1 that cycle.
- ADDI (opcode 0010011), mem_ready=1 → FETCH, DECODE, EXEC_I, ALU_WB. imm_src=000. reg_write and instr_retired high in cycle 4 only.
- SW, then LW, with mem_ready delayed 3 cycles each → imm_src=001 then 000. mem_we=1 only for the store. mem_req held 4 cycles per access. Load retires in MEMWB.
- BNE with zero=1, then zero=0 → pc_write=0, then 1 in BRANCH. imm_src=010. instr_retired=1 both times.
- JALR, then LUI → JALR path: pc_write in JALR, then JALR_LINK, then ALU_WB reg_write. LUI: imm_src=100, a=11.
- MAX_WAIT=4, mem_ready stuck 0 in FETCH → HALT after 4 wait cycles. bus_err=1 held until rst_n. Opcode 0000000 with ILLEGAL_INSTR_TRAP_EN → illegal_instr=1; without it → returns to FETCH.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I datapath, including the memory handshake timeout.
// Optional build macro ILLEGAL_INSTR_TRAP_EN: unknown opcodes and bad branch funct3 trap instead of acting as NOPs.
module multicycle_ctrl #(
    parameter int MAX_WAIT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       instr_retired,
    output logic       bus_err,
    output logic       illegal_instr
);
    // Handshake: mem_req is held high until mem_ready is sampled high; the
    // access completes in that same cycle and the FSM advances on that edge.

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    typedef enum logic [4:0] {
        S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_JALR_LINK,
        S_LUI, S_HALT, S_TRAP
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       bus_err_q, bus_err_d;
    logic [2:0] imm_fmt;
    logic       br_taken;
    logic       br_bad;

    always_comb begin
        imm_fmt = 3'b000;
        case (opcode)
            OP_STORE:          imm_fmt = 3'b001;
            OP_BR:             imm_fmt = 3'b010;
            OP_JAL:            imm_fmt = 3'b011;
            OP_LUI, OP_AUIPC:  imm_fmt = 3'b100;
            OP_SYS:            imm_fmt = 3'b101;
            default:           imm_fmt = 3'b000;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        br_bad   = 1'b0;
        case (funct3)
            3'b000:  br_taken = zero;
            3'b001:  br_taken = !zero;
            3'b100:  br_taken = lt;
            3'b101:  br_taken = !lt;
            3'b110:  br_taken = ltu;
            3'b111:  br_taken = !ltu;
            default: br_bad   = 1'b1;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        bus_err_d     = bus_err_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        imm_src       = imm_fmt;
        instr_retired = 1'b0;

        case (state_q)
            S_RST: begin
                imm_src = 3'b000;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_REG:            state_d = S_EXEC_R;
                    OP_IMM:            state_d = S_EXEC_I;
                    OP_BR:             state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_ALU_WB;
`ifdef ILLEGAL_INSTR_TRAP_EN
                    default:           state_d = S_TRAP;
`else
                    default:           state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                adr_src = 1'b1;
                mem_req = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src    = 2'b01;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWR: begin
                adr_src = 1'b1;
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) begin
                    instr_retired = 1'b1;
                    state_d       = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
`ifdef ILLEGAL_INSTR_TRAP_EN
                if (br_bad) begin
                    state_d = S_TRAP;
                end else begin
                    pc_write      = br_taken;
                    instr_retired = 1'b1;
                    state_d       = S_FETCH;
                end
`else
                // Reserved funct3 values fall through as a not-taken branch.
                pc_write      = br_taken && !br_bad;
                instr_retired = 1'b1;
                state_d       = S_FETCH;
`endif
            end
            S_JAL: begin
                pc_write  = 1'b1;
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = S_ALU_WB;
            end
            S_JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = 1'b1;
                state_d    = S_JALR_LINK;
            end
            S_JALR_LINK: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = S_ALU_WB;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                state_d   = S_ALU_WB;
            end
            default: begin
                // HALT and TRAP are terminal until reset.
                imm_src = 3'b000;
            end
        endcase

        if (mem_req && !mem_ready && wait_cnt_q == WAIT_LAST) begin
            state_d   = S_HALT;
            bus_err_d = 1'b1;
        end

        wait_cnt_d = (mem_req && !mem_ready && state_d == state_q) ? wait_cnt_q + 8'd1 : 8'd0;
    end

`ifdef ILLEGAL_INSTR_TRAP_EN
    logic illegal_q, illegal_d;

    always_comb begin
        illegal_d = illegal_q || (state_d == S_TRAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_q <= 1'b0;
        else        illegal_q <= illegal_d;
    end

    assign illegal_instr = illegal_q;
`else
    assign illegal_instr = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RST;
            wait_cnt_q <= 8'd0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed table-driven bench for multicycle_ctrl (MAX_WAIT=4), plus hand-written
// sequences for traps, timeout and reset mid-instruction.
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BAD   = 7'b0000000;

    // Packed order: mem_req mem_we adr_src ir_write pc_write reg_write
    // result_src[2] a[2] b[2] alu_op[2] imm_src[3] retired bus_err illegal
    localparam logic [19:0] HALT_EXP = 20'b10;
    localparam logic [19:0] TRAP_EXP = 20'b01;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b1;
    logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0] imm_src;
    logic       instr_retired, bus_err, illegal_instr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .imm_src(imm_src), .instr_retired(instr_retired),
        .bus_err(bus_err), .illegal_instr(illegal_instr)
    );

    typedef struct {
        logic        rst_n;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        z, lt, ltu, rdy;
        logic [19:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [19:0] c(input logic mr, input logic mw, input logic ad,
                                      input logic irw, input logic pcw, input logic rw,
                                      input logic [1:0] rs, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] op,
                                      input logic [2:0] imm, input logic ret);
        return {mr, mw, ad, irw, pcw, rw, rs, a, b, op, imm, ret, 2'b00};
    endfunction

    task automatic add(input logic r, input logic [6:0] op, input logic [2:0] f3,
                       input logic z, input logic l, input logic lu, input logic rdy,
                       input logic [19:0] exp, input string name);
        vec_t v;
        v.rst_n = r; v.op = op; v.f3 = f3; v.z = z; v.lt = l; v.ltu = lu;
        v.rdy = rdy; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance past the edge.
    task automatic step(input logic r, input logic [6:0] op, input logic [2:0] f3,
                        input logic z, input logic l, input logic lu, input logic rdy,
                        input logic [19:0] exp, input string name);
        logic [19:0] act;
        rst_n = r; opcode = op; funct3 = f3; zero = z; lt = l; ltu = lu; mem_ready = rdy;
        @(negedge clk);
        act = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, result_src,
               alu_src_a, alu_src_b, alu_op, imm_src, instr_retired, bus_err, illegal_instr};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [6:0] op);
        step(1'b0, op, 3'b000, 0, 0, 0, 1, 20'b0, "rst_held");
        step(1'b1, op, 3'b000, 0, 0, 0, 1, 20'b0, "rst_release");
    endtask

    initial begin
        // Reset, then ADDI with instant memory.
        add(0, OP_IMM, 3'b000, 0,0,0,1, 20'b0, "rst0");
        add(0, OP_IMM, 3'b000, 0,0,0,1, 20'b0, "rst1");
        add(1, OP_IMM, 3'b000, 0,0,0,1, 20'b0, "rst_rel");
        add(1, OP_IMM, 3'b000, 0,0,0,1, c(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0), "addi_fetch");
        add(1, OP_IMM, 3'b000, 0,0,0,1, c(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0), "addi_decode");
        add(1, OP_IMM, 3'b000, 0,0,0,1, c(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,3'b000,0), "addi_exec");
        add(1, OP_IMM, 3'b000, 0,0,0,1, c(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,1), "addi_wb");
        // SW, data access delayed 3 cycles.
        add(1, OP_STORE, 3'b010, 0,0,0,1, c(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b001,0), "sw_fetch");
        add(1, OP_STORE, 3'b010, 0,0,0,1, c(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b001,0), "sw_decode");
        add(1, OP_STORE, 3'b010, 0,0,0,1, c(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b001,0), "sw_memadr");
        for (int i = 0; i < 3; i++)
            add(1, OP_STORE, 3'b010, 0,0,0,0, c(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b001,0), "sw_wait");
        add(1, OP_STORE, 3'b010, 0,0,0,1, c(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b001,1), "sw_done");
        // LW, data access delayed 3 cycles.
        add(1, OP_LOAD, 3'b010, 0,0,0,1, c(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0), "lw_fetch");
        add(1, OP_LOAD, 3'b010, 0,0,0,1, c(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0), "lw_decode");
        add(1, OP_LOAD, 3'b010, 0,0,0,1, c(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0), "lw_memadr");
        for (int i = 0; i < 3; i++)
            add(1, OP_LOAD, 3'b010, 0,0,0,0, c(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0), "lw_wait");
        add(1, OP_LOAD, 3'b010, 0,0,0,1, c(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0), "lw_done");
        add(1, OP_LOAD, 3'b010, 0,0,0,1, c(0,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,1), "lw_memwb");
        // BNE zero=1 (not taken), BNE zero=0 (taken), BGE lt=1 (not taken).
        add(1, OP_BR, 3'b001, 1,0,0,1, c(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b010,0), "bne1_fetch");
        add(1, OP_BR, 3'b001, 1,0,0,1, c(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b010,0), "bne1_decode");
        add(1, OP_BR, 3'b001, 1,0,0,1, c(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b01,3'b010,1), "bne1_branch");
        add(1, OP_BR, 3'b001, 0,0,0,1, c(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b010,0), "bne0_fetch");
        add(1, OP_BR, 3'b001, 0,0,0,1, c(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b010,0), "bne0_decode");
        add(1, OP_BR, 3'b001, 0,0,0,1, c(0,0,0,0,1,0,2'b00,2'b10,2'b00,2'b01,3'b010,1), "bne0_branch");
        add(1, OP_BR, 3'b101, 0,1,0,1, c(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b010,0), "bge_fetch");
        add(1, OP_BR, 3'b101, 0,1,0,1, c(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b010,0), "bge_decode");
        add(1, OP_BR, 3'b101, 0,1,0,1, c(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b01,3'b010,1), "bge_branch");
        // JALR then LUI.
        add(1, OP_JALR, 3'b000, 0,0,0,1, c(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0), "jalr_fetch");
        add(1, OP_JALR, 3'b000, 0,0,0,1, c(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0), "jalr_decode");
        add(1, OP_JALR, 3'b000, 0,0,0,1, c(0,0,0,0,1,0,2'b10,2'b10,2'b01,2'b00,3'b000,0), "jalr_target");
        add(1, OP_JALR, 3'b000, 0,0,0,1, c(0,0,0,0,0,0,2'b00,2'b01,2'b10,2'b00,3'b000,0), "jalr_link");
        add(1, OP_JALR, 3'b000, 0,0,0,1, c(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,1), "jalr_wb");
        add(1, OP_LUI, 3'b000, 0,0,0,1, c(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b100,0), "lui_fetch");
        add(1, OP_LUI, 3'b000, 0,0,0,1, c(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b100,0), "lui_decode");
        add(1, OP_LUI, 3'b000, 0,0,0,1, c(0,0,0,0,0,0,2'b00,2'b11,2'b01,2'b00,3'b100,0), "lui_exec");
        add(1, OP_LUI, 3'b000, 0,0,0,1, c(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b100,1), "lui_wb");
        // JAL, R-type, AUIPC.
        add(1, OP_JAL, 3'b000, 0,0,0,1, c(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b011,0), "jal_fetch");
        add(1, OP_JAL, 3'b000, 0,0,0,1, c(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b011,0), "jal_decode");
        add(1, OP_JAL, 3'b000, 0,0,0,1, c(0,0,0,0,1,0,2'b00,2'b01,2'b10,2'b00,3'b011,0), "jal_exec");
        add(1, OP_JAL, 3'b000, 0,0,0,1, c(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b011,1), "jal_wb");
        add(1, OP_REG, 3'b000, 0,0,0,1, c(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0), "add_fetch");
        add(1, OP_REG, 3'b000, 0,0,0,1, c(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0), "add_decode");
        add(1, OP_REG, 3'b000, 0,0,0,1, c(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b000,0), "add_exec");
        add(1, OP_REG, 3'b000, 0,0,0,1, c(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,1), "add_wb");
        add(1, OP_AUIPC, 3'b000, 0,0,0,1, c(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b100,0), "auipc_fetch");
        add(1, OP_AUIPC, 3'b000, 0,0,0,1, c(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b100,0), "auipc_decode");
        add(1, OP_AUIPC, 3'b000, 0,0,0,1, c(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b100,1), "auipc_wb");

        #1;
        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].rst_n, vecs[i].op, vecs[i].f3, vecs[i].z, vecs[i].lt,
                 vecs[i].ltu, vecs[i].rdy, vecs[i].exp, vecs[i].name);

        // Reserved branch funct3 with every flag set that could make it look taken.
        step(1, OP_BR, 3'b010, 0,1,1,1, c(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b010,0), "badbr_fetch");
        step(1, OP_BR, 3'b010, 0,1,1,1, c(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b010,0), "badbr_decode");
`ifdef ILLEGAL_INSTR_TRAP_EN
        step(1, OP_BR, 3'b010, 0,1,1,1, c(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b01,3'b010,0), "badbr_branch");
        step(1, OP_IMM, 3'b000, 0,0,0,1, TRAP_EXP, "badbr_trap");
`else
        step(1, OP_BR, 3'b010, 0,1,1,1, c(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b01,3'b010,1), "badbr_branch");
        step(1, OP_IMM, 3'b000, 0,0,0,1, c(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0), "badbr_next");
`endif
        do_reset(OP_BAD);

        // Unknown opcode 0000000.
        step(1, OP_BAD, 3'b000, 0,0,0,1, c(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0), "bad_fetch");
        step(1, OP_BAD, 3'b000, 0,0,0,1, c(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0), "bad_decode");
`ifdef ILLEGAL_INSTR_TRAP_EN
        step(1, OP_BAD, 3'b000, 0,0,0,1, TRAP_EXP, "bad_trap");
        step(1, OP_BAD, 3'b000, 0,0,0,1, TRAP_EXP, "bad_trap_sticky");
`else
        step(1, OP_BAD, 3'b000, 0,0,0,1, c(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0), "bad_nop_fetch");
        step(1, OP_BAD, 3'b000, 0,0,0,1, c(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0), "bad_nop_decode");
`endif
        do_reset(OP_IMM);

        // Fetch timeout: 4 wait cycles, then HALT with bus_err held.
        for (int i = 0; i < 4; i++)
            step(1, OP_IMM, 3'b000, 0,0,0,0, c(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0), "to_wait");
        step(1, OP_IMM, 3'b000, 0,0,0,1, HALT_EXP, "to_halt");
        step(1, OP_IMM, 3'b000, 0,0,0,1, HALT_EXP, "to_halt_hold");
        do_reset(OP_IMM);

        // mem_ready arriving in the last allowed wait cycle completes normally.
        for (int i = 0; i < 3; i++)
            step(1, OP_IMM, 3'b000, 0,0,0,0, c(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0), "edge_wait");
        step(1, OP_IMM, 3'b000, 0,0,0,1, c(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0), "edge_done");
        step(1, OP_IMM, 3'b000, 0,0,0,1, c(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0), "edge_decode");
        step(1, OP_IMM, 3'b000, 0,0,0,1, c(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,3'b000,0), "edge_exec");
        step(1, OP_IMM, 3'b000, 0,0,0,1, c(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,1), "edge_wb");

        // Reset during a pending store: no write completion may appear.
        step(1, OP_STORE, 3'b010, 0,0,0,1, c(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b001,0), "mid_fetch");
        step(1, OP_STORE, 3'b010, 0,0,0,1, c(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b001,0), "mid_decode");
        step(1, OP_STORE, 3'b010, 0,0,0,1, c(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b001,0), "mid_memadr");
        step(1, OP_STORE, 3'b010, 0,0,0,0, c(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b001,0), "mid_memwr");
        step(0, OP_STORE, 3'b010, 0,0,0,1, 20'b0, "mid_reset");
        step(1, OP_STORE, 3'b010, 0,0,0,1, 20'b0, "mid_release");
        step(1, OP_STORE, 3'b010, 0,0,0,1, c(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b001,0), "mid_refetch");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
